// File: rtl/i2c_target_registers.sv
// I2C target answering one 7-bit address, exposing an 8-bit register file with pointer auto-increment.
// Optional: define I2C_TARGET_SPIKE_FILTER_EN to add a 3-sample glitch filter on scl/sda.
module i2c_target_registers #(
    parameter logic [6:0] Address            = 7'h50,
    parameter int         NrOfRegisters      = 16,
    parameter int         SynchronizerStages = 2
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               scl,
    inout  wire                                sda,
    output logic [NrOfRegisters-1:0][7:0]      registers,
    output logic                               writeStrobe,
    output logic [$clog2(NrOfRegisters)-1:0]   writeIndex,
    output logic                               busy
);

    localparam int         PW      = $clog2(NrOfRegisters);
    localparam logic [8:0] NrLimit = 9'(NrOfRegisters);

    typedef enum logic [3:0] {
        S_IDLE,
        S_ADDRESS,
        S_ACK_ADDRESS,
        S_POINTER,
        S_ACK_POINTER,
        S_WRITE_DATA,
        S_ACK_WRITE,
        S_READ_DATA,
        S_READ_ACK
    } state_t;

    state_t                  r_state, w_state_next;
    logic [3:0]              r_bit_cnt, w_bit_cnt_next;
    logic [7:0]              r_shift, w_shift_next;
    logic [PW-1:0]           r_pointer, w_pointer_next;
    logic                    r_sda_low, w_sda_low_next;
    logic                    r_busy, w_busy_next;
    logic                    r_write_strobe;
    logic [PW-1:0]           r_write_index;
    logic                    w_write_en;
    logic [7:0]              r_registers [NrOfRegisters];

    logic [SynchronizerStages-1:0] r_scl_sync, r_sda_sync;
    logic                    w_scl, w_sda;
    logic                    r_scl_prev, r_sda_prev;
    logic                    w_scl_rise, w_scl_fall, w_start, w_stop;
    logic                    w_bit_in, w_byte_done, w_receiving;
    logic [PW-1:0]           w_pointer_inc;
    logic [7:0]              w_read_cur, w_read_inc;

    assign sda = r_sda_low ? 1'b0 : 1'bz;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
        end else begin
            r_scl_sync <= {r_scl_sync[SynchronizerStages-2:0], scl};
            r_sda_sync <= {r_sda_sync[SynchronizerStages-2:0], sda};
        end
    end

`ifdef I2C_TARGET_SPIKE_FILTER_EN
    // A level is accepted only once three consecutive samples agree.
    logic [2:0] r_scl_hist, r_sda_hist, w_scl_hist_next, w_sda_hist_next;
    logic       r_scl_filt, r_sda_filt;

    assign w_scl_hist_next = {r_scl_hist[1:0], r_scl_sync[SynchronizerStages-1]};
    assign w_sda_hist_next = {r_sda_hist[1:0], r_sda_sync[SynchronizerStages-1]};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_scl_hist <= '1;
            r_sda_hist <= '1;
            r_scl_filt <= 1'b1;
            r_sda_filt <= 1'b1;
        end else begin
            r_scl_hist <= w_scl_hist_next;
            r_sda_hist <= w_sda_hist_next;
            if (&w_scl_hist_next)       r_scl_filt <= 1'b1;
            else if (~|w_scl_hist_next) r_scl_filt <= 1'b0;
            if (&w_sda_hist_next)       r_sda_filt <= 1'b1;
            else if (~|w_sda_hist_next) r_sda_filt <= 1'b0;
        end
    end

    assign w_scl = r_scl_filt;
    assign w_sda = r_sda_filt;
`else
    assign w_scl = r_scl_sync[SynchronizerStages-1];
    assign w_sda = r_sda_sync[SynchronizerStages-1];
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_scl_prev <= 1'b1;
            r_sda_prev <= 1'b1;
        end else begin
            r_scl_prev <= w_scl;
            r_sda_prev <= w_sda;
        end
    end

    assign w_scl_rise  = w_scl & ~r_scl_prev;
    assign w_scl_fall  = ~w_scl & r_scl_prev;
    assign w_start     = r_scl_prev & w_scl & r_sda_prev & ~w_sda;
    assign w_stop      = r_scl_prev & w_scl & ~r_sda_prev & w_sda;
    assign w_bit_in    = w_scl_rise && (r_bit_cnt != 4'd8);
    assign w_byte_done = w_scl_fall && (r_bit_cnt == 4'd8);
    assign w_receiving = (r_state == S_ADDRESS) || (r_state == S_POINTER) || (r_state == S_WRITE_DATA);

    assign w_pointer_inc = (r_pointer == PW'(NrOfRegisters - 1)) ? '0 : r_pointer + PW'(1);
    assign w_read_cur    = r_registers[r_pointer];
    assign w_read_inc    = r_registers[w_pointer_inc];

    always_comb begin
        w_state_next   = r_state;
        w_bit_cnt_next = r_bit_cnt;
        w_shift_next   = r_shift;
        w_pointer_next = r_pointer;
        w_sda_low_next = r_sda_low;
        w_busy_next    = r_busy;
        w_write_en     = 1'b0;

        if (w_stop) begin
            w_state_next   = S_IDLE;
            w_sda_low_next = 1'b0;
            w_busy_next    = 1'b0;
        end else if (w_start) begin
            w_state_next   = S_ADDRESS;
            w_bit_cnt_next = '0;
            w_sda_low_next = 1'b0;
        end else begin
            if (w_receiving && w_bit_in) begin
                w_shift_next   = {r_shift[6:0], w_sda};
                w_bit_cnt_next = r_bit_cnt + 4'd1;
            end
            unique case (r_state)
                S_IDLE: ;
                S_ADDRESS: begin
                    if (w_byte_done) begin
                        if (r_shift[7:1] == Address) begin
                            w_state_next   = S_ACK_ADDRESS;
                            w_sda_low_next = 1'b1;
                            w_busy_next    = 1'b1;
                        end else begin
                            w_state_next = S_IDLE;
                            w_busy_next  = 1'b0;
                        end
                    end
                end
                S_ACK_ADDRESS: begin
                    if (w_scl_fall) begin
                        w_bit_cnt_next = '0;
                        if (r_shift[0]) begin
                            // Read: present the first data bit right as the ACK clock ends.
                            w_shift_next   = w_read_cur;
                            w_sda_low_next = ~w_read_cur[7];
                            w_state_next   = S_READ_DATA;
                        end else begin
                            w_sda_low_next = 1'b0;
                            w_state_next   = S_POINTER;
                        end
                    end
                end
                S_POINTER: begin
                    if (w_byte_done) begin
                        if ({1'b0, r_shift} < NrLimit) begin
                            w_pointer_next = r_shift[PW-1:0];
                            w_sda_low_next = 1'b1;
                            w_state_next   = S_ACK_POINTER;
                        end else begin
                            w_state_next = S_IDLE;
                            w_busy_next  = 1'b0;
                        end
                    end
                end
                S_ACK_POINTER, S_ACK_WRITE: begin
                    if (w_scl_fall) begin
                        w_sda_low_next = 1'b0;
                        w_bit_cnt_next = '0;
                        w_state_next   = S_WRITE_DATA;
                    end
                end
                S_WRITE_DATA: begin
                    if (w_byte_done) begin
                        w_write_en     = 1'b1;
                        w_pointer_next = w_pointer_inc;
                        w_sda_low_next = 1'b1;
                        w_state_next   = S_ACK_WRITE;
                    end
                end
                S_READ_DATA: begin
                    if (w_scl_rise && r_bit_cnt != 4'd8) begin
                        w_bit_cnt_next = r_bit_cnt + 4'd1;
                    end else if (w_scl_fall) begin
                        if (r_bit_cnt == 4'd8) begin
                            w_sda_low_next = 1'b0;
                            w_bit_cnt_next = '0;
                            w_state_next   = S_READ_ACK;
                        end else begin
                            w_shift_next   = {r_shift[6:0], 1'b0};
                            w_sda_low_next = ~r_shift[6];
                        end
                    end
                end
                S_READ_ACK: begin
                    // bit counter doubles as "master ACK seen" flag.
                    if (w_scl_rise) begin
                        if (w_sda) begin
                            w_state_next = S_IDLE;
                            w_busy_next  = 1'b0;
                        end else begin
                            w_bit_cnt_next = 4'd1;
                        end
                    end else if (w_scl_fall && r_bit_cnt == 4'd1) begin
                        w_pointer_next = w_pointer_inc;
                        w_shift_next   = w_read_inc;
                        w_sda_low_next = ~w_read_inc[7];
                        w_bit_cnt_next = '0;
                        w_state_next   = S_READ_DATA;
                    end
                end
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_bit_cnt      <= '0;
            r_shift        <= '0;
            r_pointer      <= '0;
            r_sda_low      <= 1'b0;
            r_busy         <= 1'b0;
            r_write_strobe <= 1'b0;
            r_write_index  <= '0;
        end else begin
            r_state        <= w_state_next;
            r_bit_cnt      <= w_bit_cnt_next;
            r_shift        <= w_shift_next;
            r_pointer      <= w_pointer_next;
            r_sda_low      <= w_sda_low_next;
            r_busy         <= w_busy_next;
            r_write_strobe <= w_write_en;
            if (w_write_en) r_write_index <= r_pointer;
        end
    end

    for (genvar gi = 0; gi < NrOfRegisters; gi++) begin : g_reg
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                r_registers[gi] <= '0;
            end else if (w_write_en && r_pointer == PW'(gi)) begin
                r_registers[gi] <= r_shift;
            end
        end
        assign registers[gi] = r_registers[gi];
    end

    assign writeStrobe = r_write_strobe;
    assign writeIndex  = r_write_index;
    assign busy        = r_busy;

endmodule
